// File: rtl/led_pwm_engine.sv
// Bit-plane PWM LED driver: a shadow bank is filled by valid/ready beats and copied to the active bank in LOAD. Frame = LOAD, planes, DONE; in_ready drops while shadow is full or in LOAD.
// LED_PWM_DITHER_EN adds reduced depth (mode=1): plane weights are halved, and LSB plane 0 is shown on odd frames only.
module led_pwm_engine #(
  parameter int CH = 16,
  parameter int BW = 16
) (
  input  logic          GCK,
  input  logic          rst_n,
  input  logic          Vsync,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  input  logic          err_clr,
  output logic [CH-1:0] OUT,
  output logic          frame_done,
  output logic          underrun,
  output logic          busy
);
  localparam int PW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int BIW = $clog2(BW);
  localparam logic [BW-1:0]  ONE  = BW'(1);
  localparam logic [BIW-1:0] BONE = BIW'(1);
  localparam logic [BIW-1:0] TOP  = BIW'(BW - 1);
  localparam logic [PW-1:0]  LAST = PW'(CH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLANE, DONE} state_t;
  state_t state, state_nxt;

  logic [BW-1:0]  shadow [CH];
  logic [BW-1:0]  active [CH];
  logic [PW-1:0]  wr_ptr;
  logic           shadow_full;
  logic [BIW-1:0] plane;
  logic [BW-1:0]  dur_cnt;
  logic           wr_en;
  logic           last_plane;
  logic           reduced;
  logic           red_load;

  // Cycles-minus-one spent in plane b; the counter counts down to zero.
  function automatic logic [BW-1:0] dur_m1(input logic [BIW-1:0] b, input logic red);
    if (red)
      dur_m1 = (b == '0) ? '0 : (ONE << (b - BONE)) - ONE;
    else
      dur_m1 = (ONE << b) - ONE;
  endfunction

`ifdef LED_PWM_DITHER_EN
  logic mode_q;
  logic parity;

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      parity <= 1'b0;
    end else begin
      if (state == LOAD) mode_q <= mode;
      if (state == DONE) parity <= ~parity;
    end
  end

  assign reduced    = mode_q;
  assign red_load   = mode;
  // Even reduced frames end after plane 1; plane 0 only gets a slot on odd frames.
  assign last_plane = (plane == '0) || (mode_q && !parity && plane == BONE);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign reduced     = 1'b0;
  assign red_load    = 1'b0;
  assign last_plane  = (plane == '0);
`endif

  assign in_ready   = !shadow_full && (state != LOAD);
  assign wr_en      = in_valid && in_ready;
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Vsync) state_nxt = LOAD;
      LOAD:    state_nxt = Vsync ? PLANE : IDLE;
      PLANE: begin
        if (!Vsync)
          state_nxt = IDLE;
        else if (dur_cnt == '0 && last_plane)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    OUT = '0;
    if (state == PLANE && Vsync)
      for (int c = 0; c < CH; c++) OUT[c] = active[c][plane];
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      shadow_full <= 1'b0;
      plane       <= '0;
      dur_cnt     <= '0;
      underrun    <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (wr_en) begin
        shadow[wr_ptr] <= in_data;
        if (wr_ptr == LAST) begin
          wr_ptr      <= '0;
          shadow_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + PW'(1);
        end
      end

      if (state == LOAD) begin
        if (shadow_full) begin
          active      <= shadow;
          shadow_full <= 1'b0;
          wr_ptr      <= '0;
        end
        plane   <= TOP;
        dur_cnt <= dur_m1(TOP, red_load);
      end else if (state == PLANE) begin
        if (dur_cnt != '0) begin
          dur_cnt <= dur_cnt - ONE;
        end else if (!last_plane) begin
          plane   <= plane - BONE;
          dur_cnt <= dur_m1(plane - BONE, reduced);
        end
      end

      // A new underrun takes priority over a simultaneous clear.
      if (state == LOAD && !shadow_full)
        underrun <= 1'b1;
      else if (err_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Bench for led_pwm_engine (CH=4, BW=4): random banks and modes are checked cycle by cycle against a plane-sequence reference model.
module tb_led_pwm_engine;
  localparam int CH = 4;
  localparam int BW = 4;
`ifdef LED_PWM_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic          GCK = 1'b0;
  logic          rst_n = 1'b0;
  logic          Vsync = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready, frame_done, underrun, busy;
  logic [CH-1:0] OUT;

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents, write pointer, flags and the plane index shown on each PLANE cycle.
  logic [BW-1:0] m_shadow [CH];
  logic [BW-1:0] m_active [CH];
  int            m_wr;
  bit            m_full, m_underrun, m_parity;
  int            plane_q[$];

  led_pwm_engine #(.CH(CH), .BW(BW)) dut (
    .GCK(GCK), .rst_n(rst_n), .Vsync(Vsync), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .err_clr(err_clr), .OUT(OUT), .frame_done(frame_done),
    .underrun(underrun), .busy(busy)
  );

  always #5 GCK = ~GCK;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = '0;
      m_active[c] = '0;
    end
    m_wr = 0; m_full = 0; m_underrun = 0; m_parity = 0;
  endfunction

  function automatic void model_load(input bit md);
    int n;
    if (m_full) begin
      for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
      m_full = 0;
      m_wr = 0;
    end else begin
      m_underrun = 1;
    end
    plane_q.delete();
    for (int b = BW - 1; b >= 0; b--) begin
      if (md && DITHER) n = (b == 0) ? int'(m_parity) : (1 << (b - 1));
      else n = 1 << b;
      repeat (n) plane_q.push_back(b);
    end
  endfunction

  task automatic write_beat(input logic [BW-1:0] v);
    checks++;
    if (in_ready !== !m_full) begin
      errors++;
      $display("FAIL write_ready: got %b expected %b", in_ready, !m_full);
    end
    in_valid = 1'b1;
    in_data = v;
    if (!m_full) begin
      m_shadow[m_wr] = v;
      m_wr = (m_wr + 1) % CH;
      if (m_wr == 0) m_full = 1;
    end
    @(negedge GCK);
    in_valid = 1'b0;
    in_data = BW'($urandom);
  endtask

  task automatic write_random(input int n);
    for (int i = 0; i < n; i++) write_beat(BW'($urandom));
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after DONE.
  task automatic run_frame(input bit md, input bit keep, input bit clr_load);
    int            cnt [CH];
    int            exp_c;
    bit            par;
    logic [CH-1:0] exp_out;
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    mode = md;
    Vsync = 1'b1;
    err_clr = clr_load;
    @(negedge GCK);
    checks++;
    if ({busy, in_ready, OUT, frame_done} !== {1'b1, 1'b0, {CH{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL load_state: got busy=%b rdy=%b out=%b done=%b", busy, in_ready, OUT, frame_done);
    end
    par = m_parity;
    if (clr_load) m_underrun = 0;
    model_load(md);
    for (int k = 0; k < plane_q.size(); k++) begin
      @(negedge GCK);
      err_clr = 1'b0;
      mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) exp_out[c] = m_active[c][plane_q[k]];
      checks++;
      if ({OUT, frame_done} !== {exp_out, 1'b0}) begin
        errors++;
        $display("FAIL plane_out k=%0d: got out=%b done=%b expected out=%b done=0", k, OUT, frame_done, exp_out);
      end
      for (int c = 0; c < CH; c++) if (OUT[c]) cnt[c]++;
    end
    @(negedge GCK);
    checks++;
    if ({frame_done, busy, OUT, underrun} !== {1'b1, 1'b1, {CH{1'b0}}, m_underrun}) begin
      errors++;
      $display("FAIL done_state: got done=%b busy=%b out=%b underrun=%b expected 1 1 0 %b",
               frame_done, busy, OUT, underrun, m_underrun);
    end
    m_parity = ~m_parity;
    for (int c = 0; c < CH; c++) begin
      if (md && DITHER) exp_c = (int'(m_active[c]) >> 1) + ((par && m_active[c][0]) ? 1 : 0);
      else exp_c = int'(m_active[c]);
      checks++;
      if (cnt[c] !== exp_c) begin
        errors++;
        $display("FAIL high_count ch%0d: got %0d expected %0d", c, cnt[c], exp_c);
      end
    end
    if (!keep) Vsync = 1'b0;
    @(negedge GCK);
    checks++;
    if ({busy, frame_done, OUT} !== '0) begin
      errors++;
      $display("FAIL idle_after: got busy=%b done=%b out=%b expected all 0", busy, frame_done, OUT);
    end
  endtask

  task automatic clear_underrun();
    err_clr = 1'b1;
    @(negedge GCK);
    err_clr = 1'b0;
    m_underrun = 0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got underrun=%b expected 0", underrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge GCK);
    checks++;
    if ({OUT, busy, frame_done, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%b busy=%b done=%b underrun=%b expected all 0", OUT, busy, frame_done, underrun);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge GCK);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_full_frame();
    write_beat(4'hF);
    write_beat(4'h0);
    write_beat(4'h5);
    write_beat(4'h8);
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    repeat (4) begin
      write_random(CH);
      run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    write_random(CH);
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    clear_underrun();
  endtask

  task automatic test_underrun();
    write_random(2);
    run_frame(1'b0, 1'b0, 1'b0);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: got %b expected 1", underrun);
    end
    write_random(2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", in_ready);
    end
    clear_underrun();
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got %b expected 1", underrun);
    end
    clear_underrun();
  endtask

  task automatic test_abort();
    logic [BW-1:0] v0;
    logic [CH-1:0] exp_out;
    v0 = BW'($urandom);
    v0[2] = 1'b1;
    write_beat(v0);
    write_random(CH - 1);
    mode = 1'b0;
    Vsync = 1'b1;
    @(negedge GCK);
    model_load(1'b0);
    for (int k = 0; k <= 9; k++) begin
      @(negedge GCK);
      for (int c = 0; c < CH; c++) exp_out[c] = m_active[c][plane_q[k]];
      checks++;
      if (OUT !== exp_out) begin
        errors++;
        $display("FAIL abort_pre k=%0d: got %b expected %b", k, OUT, exp_out);
      end
    end
    Vsync = 1'b0;
    #1;
    checks++;
    if ({OUT, frame_done} !== '0) begin
      errors++;
      $display("FAIL abort_gate: got out=%b done=%b expected 0", OUT, frame_done);
    end
    @(negedge GCK);
    checks++;
    if ({busy, frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, frame_done);
    end
  endtask

  task automatic test_load_collision();
    logic [BW-1:0] cv;
    write_random(CH);
    cv = BW'($urandom);
    mode = 1'b0;
    Vsync = 1'b1;
    in_valid = 1'b1;
    in_data = cv;
    @(negedge GCK);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL collision_load_rdy: got %b expected 0", in_ready);
    end
    model_load(1'b0);
    @(negedge GCK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL collision_next_rdy: got %b expected 1", in_ready);
    end
    m_shadow[0] = cv;
    m_wr = 1;
    @(negedge GCK);
    in_valid = 1'b0;
    Vsync = 1'b0;
    @(negedge GCK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_idle: got busy=%b expected 0", busy);
    end
    write_random(CH - 1);
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    write_random(2);
    Vsync = 1'b1;
    mode = 1'b0;
    repeat (4) @(negedge GCK);
    checks++;
    if ({busy, underrun} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b underrun=%b expected 1 1", busy, underrun);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({OUT, busy, frame_done, underrun} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got out=%b busy=%b done=%b underrun=%b expected all 0", OUT, busy, frame_done, underrun);
    end
    @(negedge GCK);
    rst_n = 1'b1;
    Vsync = 1'b0;
    model_reset();
    @(negedge GCK);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_release: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
    run_frame(1'b0, 1'b0, 1'b0);
    clear_underrun();
    write_random(CH);
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

`ifdef LED_PWM_DITHER_EN
  task automatic test_reduced();
    write_beat(4'h5);
    write_random(CH - 1);
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    clear_underrun();
    write_random(CH);
    run_frame(1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    clear_underrun();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_random_frames();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_load_collision();
    test_mid_reset();
`ifdef LED_PWM_DITHER_EN
    test_reduced();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_engine.md
LED_PWM_ENGINE -- requirements
Module: led_pwm_engine

Interface
REQ-001 SHALL have parameter CH, default 16: number of LED output channels.
REQ-002 SHALL have parameter BW, default 16: gray-scale bit depth per channel, legal range 2..16.
REQ-003 SHALL have port GCK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Vsync, input, 1 bit: display enable; a frame starts while high.
REQ-006 SHALL have port mode, input, 1 bit: 0 = full depth; 1 = reduced depth with LSB dither.
REQ-007 SHALL have port in_valid, input, 1 bit: gray value beat valid.
REQ-008 SHALL have port in_ready, output, 1 bit: shadow bank can accept a beat.
REQ-009 SHALL have port in_data, input, BW bits: gray value for channel wr_ptr.
REQ-010 SHALL have port err_clr, input, 1 bit: clears underrun.
REQ-011 SHALL have port OUT, output, CH bits: PWM drive, one bit per channel.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a completed frame.
REQ-013 SHALL have port underrun, output, 1 bit: sticky flag, frame started with an incomplete shadow bank.
REQ-014 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 SHALL hold two banks of CH x BW bits: shadow (written) and active (displayed).
REQ-016 SHALL write in_data to shadow[wr_ptr] on in_valid & in_ready, then wr_ptr++; a write at wr_ptr = CH-1 sets shadow_full.
REQ-017 SHALL drive in_ready = !shadow_full && state != LOAD; in_data is ignored when in_ready = 0.
REQ-018 SHALL implement states IDLE, LOAD, PLANE and DONE; IDLE goes to LOAD when Vsync = 1, otherwise stays in IDLE.
REQ-019 SHALL, in LOAD (1 cycle), copy shadow to active if shadow_full, then clear shadow_full and set wr_ptr = 0.
REQ-020 SHALL, in LOAD when not shadow_full, keep active unchanged, set underrun, and leave wr_ptr unchanged.
REQ-021 SHALL latch mode in LOAD; mode changes mid-frame have no effect.
REQ-022 SHALL, in PLANE with full depth, step plane index b from BW-1 down to 0 with plane b lasting 2^b cycles, giving 2^BW-1 cycles in total.
REQ-023 SHALL, in PLANE with reduced depth, make planes BW-1..1 last 2^(b-1) cycles each, and make plane 0 last 1 cycle on odd frames only (skipped on even frames).
REQ-024 SHALL drive OUT[c] = active[c][b] while in PLANE and Vsync = 1, and OUT = 0 otherwise.
REQ-025 SHALL, after the last plane, enter DONE for 1 cycle: pulse frame_done, toggle frame parity, then return to IDLE (back-to-back frames while Vsync stays high).
REQ-026 SHALL, if Vsync = 0 in LOAD or PLANE, gate OUT to 0 in the same cycle and enter IDLE next cycle, with no frame_done and no parity toggle.
REQ-027 SHALL clear underrun on err_clr; if a set and a clear occur in the same cycle, set wins.
REQ-028 SHALL use a plane duration counter of BW bits with no wrap inside a frame.

Reset
REQ-029 SHALL, on rst_n = 0 and asynchronously, set: state IDLE, both banks 0, wr_ptr 0, shadow_full 0, parity even, OUT 0, frame_done 0, underrun 0, busy 0, in_ready 1 once released.
REQ-030 SHALL abandon any frame in progress when reset is asserted mid-frame; a partial shadow load is discarded.

Configuration
REQ-031 SHALL compile the reduced-depth/dither logic only when LED_PWM_DITHER_EN is defined.
REQ-032 SHALL, when LED_PWM_DITHER_EN is undefined, ignore mode and always use full depth, with no parity register present.

Verification (CH=4, BW=4)
REQ-033 SHALL verify a full-depth frame: load F,0,5,8 then Vsync = 1 -> OUT[0] high 15 cycles, OUT[1] never high, OUT[2] high 5 cycles, OUT[3] high 8 cycles; frame_done pulses 16 cycles after LOAD.
REQ-034 SHALL verify reduced depth: mode = 1 with value 5 over two frames -> OUT high 2 cycles on the even frame and 3 on the odd frame; even frame PLANE length is 7 cycles, odd is 8.
REQ-035 SHALL verify underrun: load 2 beats only, then Vsync = 1 -> underrun = 1, active keeps the previous frame values, and in_ready stays high for beats 3-4; err_clr drops underrun.
REQ-036 SHALL verify a Vsync abort: drop Vsync in plane 2 -> OUT = 0 in the same cycle, busy = 0 next cycle, no frame_done.
REQ-037 SHALL verify LOAD collision: in_valid held during LOAD -> no write in that cycle; the beat is accepted in the next cycle to shadow[0].
REQ-038 SHALL verify mid-frame reset: rst_n pulsed low in PLANE -> all outputs 0 immediately, in_ready = 1 after release.
